// File: rtl/four_bit_comparator_pkg.sv
// Shared definitions for the registered four-bit magnitude comparator.
// Holds the one-hot result encoding, the bit positions of each outcome
// inside R, and the default operand / counter widths.
package four_bit_comparator_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    // One-hot result codes: R[2] = A>B, R[1] = A==B, R[0] = A<B.
    localparam logic [2:0] RES_LT = 3'b001;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b100;

    // Bit index of each outcome inside R (also the counter index).
    localparam int R_LT = 0;
    localparam int R_EQ = 1;
    localparam int R_GT = 2;

endpackage

// File: rtl/four_bit_comparator_if.sv
// Bus interface of the comparator.
//   master : drives A, B, in_valid, signed_mode, cnt_clr; observes results.
//   slave  : the comparator; drives R, out_valid, cnt_lt/eq/gt.
// clk and rst_n are not part of the bundle and stay plain module ports.
interface four_bit_comparator_if
    import four_bit_comparator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             signed_mode;
    logic             cnt_clr;
    logic [2:0]       R;
    logic             out_valid;
    logic [CNT_W-1:0] cnt_lt;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_gt;

    modport master (
        output A, B, in_valid, signed_mode, cnt_clr,
        input  R, out_valid, cnt_lt, cnt_eq, cnt_gt
    );

    modport slave (
        input  A, B, in_valid, signed_mode, cnt_clr,
        output R, out_valid, cnt_lt, cnt_eq, cnt_gt
    );

endinterface

// File: rtl/four_bit_compare_core.sv
// Purely combinational magnitude compare of a and b.
//   a, b        : operands
//   signed_mode : 0 = unsigned, 1 = two's complement
//   lt, eq, gt  : exactly one is high for every input pair
module four_bit_compare_core
    import four_bit_comparator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Inverting the sign bit maps two's-complement order onto unsigned
    // order (-2^(W-1) becomes 0, 2^(W-1)-1 becomes all ones), so a single
    // unsigned comparator serves both modes.
    always_comb begin
        a_key = a;
        b_key = b;
        a_key[WIDTH-1] = a[WIDTH-1] ^ signed_mode;
        b_key[WIDTH-1] = b[WIDTH-1] ^ signed_mode;
        lt = (a_key < b_key);
        eq = (a_key == b_key);
        gt = (a_key > b_key);
    end

endmodule

// File: rtl/four_bit_comparator.sv
// Registered magnitude comparator with saturating outcome counters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of four_bit_comparator_if
//           inputs  A, B, in_valid, signed_mode, cnt_clr
//           outputs R (one-hot, 1-cycle latency), out_valid,
//                   cnt_lt / cnt_eq / cnt_gt (saturating)
// All outputs come straight from flops; there is no input-to-output
// combinational path.
module four_bit_comparator
    import four_bit_comparator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    four_bit_comparator_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       lt;
    logic       eq;
    logic       gt;
    logic [2:0] res_now;

    logic [2:0] r_q;
    logic [2:0] r_d;
    logic       out_valid_q;
    logic       out_valid_d;

    // Counter values gathered by outcome index (R_LT / R_EQ / R_GT).
    logic [2:0][CNT_W-1:0] cnt_all;

    four_bit_compare_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a           (bus.A),
        .b           (bus.B),
        .signed_mode (bus.signed_mode),
        .lt          (lt),
        .eq          (eq),
        .gt          (gt)
    );

    always_comb begin
        res_now        = '0;
        res_now[R_LT]  = lt;
        res_now[R_EQ]  = eq;
        res_now[R_GT]  = gt;
    end

    // R holds its last value while idle so it always stays one-hot.
    always_comb begin
        r_d         = r_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            r_d = res_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= RES_EQ;
            out_valid_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
        end
    end

    // One saturating counter per outcome; clear takes priority over a
    // simultaneous count.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (bus.cnt_clr) begin
                    cnt_d = '0;
                end else if (bus.in_valid && res_now[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign bus.R         = r_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cnt_lt    = cnt_all[R_LT];
    assign bus.cnt_eq    = cnt_all[R_EQ];
    assign bus.cnt_gt    = cnt_all[R_GT];

endmodule

// File: tb/tb_four_bit_comparator.sv
// Directed testbench for four_bit_comparator: hand-computed vectors for
// unsigned/signed compares, valid gating, counter clear, asynchronous
// reset and counter saturation.
module tb_four_bit_comparator;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    four_bit_comparator_if #(.WIDTH(4), .CNT_W(8)) bus ();

    four_bit_comparator #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Present one compare, clock it and check R/out_valid one cycle later.
    task automatic cmp(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic sm, input logic [2:0] exp_r);
        bus.A           = a;
        bus.B           = b;
        bus.signed_mode = sm;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, ".R"}, {29'd0, bus.R}, {29'd0, exp_r});
        check_eq({tag, ".ov"}, {31'd0, bus.out_valid}, 32'd1);
        $display("cmp %s A=%b B=%b sm=%0d R=%b ov=%0d", tag, a, b, sm, bus.R, bus.out_valid);
    endtask

    task automatic check_cnts(input string tag, input int lt, input int eq, input int gt);
        check_eq({tag, ".cnt_lt"}, {24'd0, bus.cnt_lt}, lt);
        check_eq({tag, ".cnt_eq"}, {24'd0, bus.cnt_eq}, eq);
        check_eq({tag, ".cnt_gt"}, {24'd0, bus.cnt_gt}, gt);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.A           = '0;
        bus.B           = '0;
        bus.in_valid    = 1'b0;
        bus.signed_mode = 1'b0;
        bus.cnt_clr     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.R", {29'd0, bus.R}, 32'h2);
        check_eq("rst.ov", {31'd0, bus.out_valid}, 32'd0);
        check_cnts("rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned less-than, back to back
        cmp("lt0", 4'b0100, 4'b1010, 1'b0, 3'b001);
        cmp("lt1", 4'b1100, 4'b1111, 1'b0, 3'b001);
        cmp("lt2", 4'b0010, 4'b1101, 1'b0, 3'b001);
        cmp("lt3", 4'b0011, 4'b1101, 1'b0, 3'b001);
        check_cnts("after_lt", 4, 0, 0);

        // Equality including boundary pairs
        cmp("eq0", 4'b1110, 4'b1110, 1'b0, 3'b010);
        cmp("eq1", 4'b1111, 4'b1111, 1'b0, 3'b010);
        cmp("eq2", 4'b1000, 4'b1000, 1'b0, 3'b010);
        cmp("eq3", 4'b0000, 4'b0000, 1'b0, 3'b010);
        check_cnts("after_eq", 4, 4, 0);

        // Greater-than
        cmp("gt0", 4'b0001, 4'b0000, 1'b0, 3'b100);
        cmp("gt1", 4'b1111, 4'b1110, 1'b0, 3'b100);
        cmp("gt2", 4'b0101, 4'b0011, 1'b0, 3'b100);
        cmp("gt3", 4'b0010, 4'b0001, 1'b0, 3'b100);
        check_cnts("after_gt", 4, 4, 4);

        // Signed vs unsigned on the same operands
        cmp("s_m1_1", 4'b1111, 4'b0001, 1'b1, 3'b001); // -1 < 1
        cmp("u_15_1", 4'b1111, 4'b0001, 1'b0, 3'b100); // 15 > 1
        cmp("s_7_m8", 4'b0111, 4'b1000, 1'b1, 3'b100); // 7 > -8
        cmp("u_7_8",  4'b0111, 4'b1000, 1'b0, 3'b001); // 7 < 8
        cmp("s_m8_m1", 4'b1000, 4'b1111, 1'b1, 3'b001); // -8 < -1
        check_cnts("after_signed", 7, 4, 6);

        // Idle cycles: out_valid drops, R and counters hold
        bus.in_valid = 1'b0;
        bus.A        = 4'b1111;
        bus.B        = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle.ov", {31'd0, bus.out_valid}, 32'd0);
            check_eq("idle.R", {29'd0, bus.R}, 32'h1);
            $display("idle cycle %0d R=%b ov=%0d", i, bus.R, bus.out_valid);
        end
        check_cnts("after_idle", 7, 4, 6);

        // Clear wins over a simultaneous count; R still updates
        bus.cnt_clr = 1'b1;
        cmp("clr", 4'b0011, 4'b0011, 1'b0, 3'b010);
        check_cnts("after_clr", 0, 0, 0);
        bus.cnt_clr = 1'b0;
        cmp("post_clr", 4'b0101, 4'b0010, 1'b0, 3'b100);
        check_cnts("post_clr", 0, 0, 1);

        // Asynchronous reset mid-stream, well away from a clock edge
        bus.A        = 4'b0001;
        bus.B        = 4'b0110;
        bus.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.R", {29'd0, bus.R}, 32'h2);
        check_eq("arst.ov", {31'd0, bus.out_valid}, 32'd0);
        check_cnts("arst", 0, 0, 0);
        $display("async reset R=%b ov=%0d", bus.R, bus.out_valid);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 300 equal compares
        bus.A           = 4'b1001;
        bus.B           = 4'b1001;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (i == 254) check_eq("sat.254", {24'd0, bus.cnt_eq}, 32'd254);
            if (i == 255) check_eq("sat.255", {24'd0, bus.cnt_eq}, 32'd255);
            if (i == 256) check_eq("sat.256", {24'd0, bus.cnt_eq}, 32'd255);
        end
        check_eq("sat.R", {29'd0, bus.R}, 32'h2);
        check_cnts("sat_end", 0, 255, 0);
        $display("saturation cnt_eq=%0d", bus.cnt_eq);

        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/four_bit_comparator.md
Name: four_bit_comparator

Overview:
Registered magnitude comparator for two 4-bit operands, producing a one-hot 3-bit result: less-than, equal or greater-than. The comparison itself is a combinational core. Its result is captured on the clock together with a valid flag. Saturating per-outcome event counters support bring-up and debug. The block sits in the datapath wherever a downstream block needs a registered A-versus-B decision.

Parameters:
WIDTH, 4, operand width in bits; the block is verified at 4 only.
CNT_W, 8, width of each saturating outcome counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
in_valid  input  1  A and B are sampled this cycle.
signed_mode  input  1  0 = unsigned compare; 1 = two's-complement compare.
cnt_clr  input  1  synchronous clear of all outcome counters.
R  output  3  registered one-hot result: R[2] = A>B, R[1] = A==B, R[0] = A<B.
out_valid  output  1  R holds the result of the in_valid cycle one clock earlier.
cnt_lt  output  CNT_W  number of valid compares with A<B.
cnt_eq  output  CNT_W  number of valid compares with A==B.
cnt_gt  output  CNT_W  number of valid compares with A>B.

Behaviour:
- Reset (rst_n low, asynchronous and immediate):
  - R = 3'b010. This is the "equal" idle code, so R is always one-hot.
  - out_valid = 0.
  - All counters = 0.
  - Reset applied mid-operation discards any in-flight result.
- Combinational core:
  - Unsigned when signed_mode = 0.
  - Sign-aware when signed_mode = 1: MSB set means negative.
  - Exactly one of lt/eq/gt is asserted for every input pair, including X-free boundary pairs such as 0000/0000 and 1111/1111.
- Latency is 1 cycle. On a rising edge with in_valid = 1:
  - R <= core result.
  - out_valid <= 1.
  - The matching counter increments.
- On a rising edge with in_valid = 0:
  - out_valid <= 0.
  - R holds its previous value.
  - Counters hold.
- Back-to-back in_valid: one result per cycle, no stall, no handshake back-pressure.
- Counters saturate at 2^CNT_W-1; they never wrap.
- cnt_clr = 1:
  - All counters load 0 on that edge.
  - If in_valid is also 1, clear wins. The current compare is not counted, but R and out_valid still update.
- signed_mode is sampled in the same cycle as A and B.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package four_bit_comparator_pkg:
  - Result encoding constants RES_LT = 3'b001, RES_EQ = 3'b010, RES_GT = 3'b100.
  - Bit index constants R_LT = 0, R_EQ = 1, R_GT = 2.
  - Default WIDTH and CNT_W.
- One sub-module, four_bit_compare_core:
  - Purely combinational.
  - Inputs: A, B, signed_mode.
  - Output: one-hot lt/eq/gt.
- The top level holds the result/valid registers and the counters.

Test Plan:
- Unsigned less-than: signed_mode = 0, in_valid = 1, drive A/B = 0100/1010, 1100/1111, 0010/1101, 0011/1101 on consecutive cycles -> R = 001 on each of the next 4 cycles with out_valid = 1; cnt_lt = 4.
- Equality: A/B = 1110/1110, 1111/1111, 1000/1000, 0000/0000 -> R = 010 each cycle; cnt_eq = 4.
- Greater-than: A/B = 0001/0000, 1111/1110, 0101/0011, 0010/0001 -> R = 100 each cycle; cnt_gt = 4.
- Signed mode: signed_mode = 1 with A = 1111 (-1), B = 0001 -> R = 001. Same operands with signed_mode = 0 -> R = 100.
- Valid gating and clear:
  - in_valid = 0 for 3 cycles -> out_valid = 0, R and counters unchanged.
  - cnt_clr = 1 together with in_valid = 1 -> counters = 0 next cycle, R still updated.
- Reset and saturation:
  - Assert rst_n = 0 asynchronously mid-stream -> R = 010, out_valid = 0, counters = 0 immediately, without waiting for a clock edge.
  - 300 consecutive equal compares -> cnt_eq stops at 255.
